seg_countdown_ctrl: RTL
=======================

Name: seg_countdown_ctrl

Overview:
- Two-digit BCD countdown timer controller that sequences the shared two-digit 7-segment decoder.
- Holds the tens and ones digits and loads them from a preset.
- Decrements once per divided tick, with start, pause and load control, and flags completion at 00.
- Outputs connect directly to the decoder's two 4-bit digit inputs.
- Guarantees every digit presented to the decoder is 0-9, because decoder codes 10-15 are undefined.

Parameters:
TICK_DIV, 12000000, clk cycles per decrement (1 Hz at the 12 MHz board clock); legal range 2 to 2^24.
DIV_W, 24, width of the tick divider counter; must hold TICK_DIV-1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load  in  1  one-cycle pulse; load preset digits and return to IDLE
start  in  1  one-cycle pulse; start or resume counting
pause  in  1  one-cycle pulse; freeze counting
preset_tens  in  4  BCD preset, tens digit
preset_ones  in  4  BCD preset, ones digit
seg_data_1  out  4  current tens digit to decoder, always 0-9
seg_data_2  out  4  current ones digit to decoder, always 0-9
running  out  1  high while in RUN
done  out  1  high while in DONE

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset (rst=1 at a clk edge):
  - state=IDLE, seg_data_1=0, seg_data_2=0, running=0, done=0, divider=0.
  - rst overrides every other input and applies mid-count.
- Preset clamp: a preset digit >9 loads as 9, independently per digit.
- States: IDLE, RUN, PAUSE, DONE. running=(state==RUN); done=(state==DONE).
- Input priority, every state: rst > load > state-specific handling. Inputs are treated as single-cycle pulses; a held level re-triggers each cycle.
- load, any state:
  - Next cycle: digits=clamped preset, state=IDLE, divider=0, done=0, running=0.
- IDLE:
  - start with digits==00 -> DONE next cycle; no decrement.
  - start with digits!=00 -> RUN next cycle, divider=0.
  - pause is ignored.
- RUN:
  - divider increments each cycle.
  - When divider==TICK_DIV-1, a tick occurs: divider returns to 0 and the digits decrement.
  - Decrement rule: if ones>0, ones-1; else ones=9 and tens-1.
  - The first tick comes exactly TICK_DIV cycles after the start edge.
  - If the decrement result is 00 -> DONE on the same edge; the pending pause is discarded.
  - Otherwise, pause -> PAUSE. A tick coinciding with pause still applies its decrement.
  - start is ignored.
- PAUSE:
  - digits and divider hold.
  - start -> RUN; the divider resumes from its held value, so RUN cycles between ticks always total TICK_DIV.
  - pause is ignored.
- DONE:
  - digits hold at 00, done=1.
  - start and pause are ignored; only load or rst leave DONE.
- Digits never underflow: decrement is evaluated only in RUN with digits!=00.
- Latency: load and state changes appear on outputs 1 cycle after the input edge.

Test Plan (TICK_DIV=4):
1. Reset: assert rst 2 cycles -> seg_data_1=0, seg_data_2=0, running=0, done=0.
   Then pulse start with no load -> done=1 next cycle; digits stay 00.
2. Full count: load preset 1,2; start at cycle T.
   - running=1 at T+1.
   - Digits 1,1 after edge T+4 and 1,0 at T+8.
   - Borrow to 0,9 at T+12.
   - 0,0 with done=1 and running=0 at T+48.
   - Digits never leave 0-9.
3. Clamp: preset_tens=4'hC, preset_ones=4'hF, load -> outputs 9,9 next cycle, state IDLE.
4. Pause/resume: load 0,5; start; pause after 2 RUN cycles; wait 20 cycles.
   - Digits stay 0,5 and running=0 during the wait.
   - Pulse start -> decrement to 0,4 exactly 2 RUN cycles later.
5. Collisions:
   - pause coinciding with a tick at 0,3 -> digits become 0,2 and state PAUSE.
   - pause coinciding with the tick from 0,1 -> 0,0 and DONE; the pause is discarded.
   - load 3,3 on the same edge as a tick in RUN -> 3,3, IDLE, running=0.
6. Reset mid-run: at 0,7 in RUN, assert rst for 1 cycle -> next cycle 0,0, IDLE, running=0, done=0.
   A following start -> DONE next cycle.

Source files
------------

// File: rtl/seg_countdown_ctrl.sv
// seg_countdown_ctrl
//   Two-digit BCD countdown timer that drives a shared two-digit 7-segment
//   decoder. Digits load from a clamped preset. They count down once per
//   divided tick while running, can pause and resume, and latch at 00 in
//   DONE. Both digit registers only ever hold 0-9, so the decoder never
//   sees one of its undefined codes.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   load         pulse: load clamped preset digits and return to IDLE
//   start        pulse: start (IDLE) or resume (PAUSE) counting
//   pause        pulse: freeze counting (RUN only)
//   preset_tens  BCD preset, tens digit (>9 loads as 9)
//   preset_ones  BCD preset, ones digit (>9 loads as 9)
//   seg_data_1   tens digit to decoder, registered, 0-9
//   seg_data_2   ones digit to decoder, registered, 0-9
//   running      registered, high while in RUN
//   done         registered, high while in DONE
module seg_countdown_ctrl #(
   parameter int unsigned TICK_DIV = 12000000,
   parameter int unsigned DIV_W    = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic [3:0] preset_tens,
   input  logic [3:0] preset_ones,
   output logic [3:0] seg_data_1,
   output logic [3:0] seg_data_2,
   output logic       running,
   output logic       done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

   state_t           state_q, state_d;
   logic [3:0]       tens_q, tens_d, ones_q, ones_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             running_q, done_q;

   logic             tick;
   logic [3:0]       tens_dec, ones_dec;
   logic             dec_zero;
   logic [3:0]       pre_tens_cl, pre_ones_cl;

   // Each preset digit is clamped on its own so an illegal code never
   // reaches the digit registers.
   assign pre_tens_cl = (preset_tens > 4'd9) ? 4'd9 : preset_tens;
   assign pre_ones_cl = (preset_ones > 4'd9) ? 4'd9 : preset_ones;

   assign tick = (div_q == DIV_MAX);

   // BCD decrement with borrow. The tens borrow cannot wrap: RUN is only
   // entered or kept with digits != 00, so tens is nonzero whenever ones is 0.
   assign ones_dec = (ones_q != 4'd0) ? ones_q - 4'd1 : 4'd9;
   assign tens_dec = (ones_q != 4'd0) ? tens_q : tens_q - 4'd1;
   assign dec_zero = (tens_dec == 4'd0) && (ones_dec == 4'd0);

   always_comb begin
      state_d = state_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      div_d   = div_q;
      if (load) begin
         state_d = S_IDLE;
         tens_d  = pre_tens_cl;
         ones_d  = pre_ones_cl;
         div_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  div_d   = '0;
                  state_d = (tens_q == 4'd0 && ones_q == 4'd0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (tick) begin
                  div_d  = '0;
                  tens_d = tens_dec;
                  ones_d = ones_dec;
                  // Reaching 00 wins over a coincident pause.
                  if (dec_zero)   state_d = S_DONE;
                  else if (pause) state_d = S_PAUSE;
               end else begin
                  div_d = div_q + DIV_W'(1);
                  if (pause) state_d = S_PAUSE;
               end
            end
            // Divider holds here so RUN time between ticks always totals TICK_DIV.
            S_PAUSE: if (start) state_d = S_RUN;
            S_DONE:  ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         tens_q    <= 4'd0;
         ones_q    <= 4'd0;
         div_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         div_q     <= div_d;
         running_q <= (state_d == S_RUN);
         done_q    <= (state_d == S_DONE);
      end
   end

   assign seg_data_1 = tens_q;
   assign seg_data_2 = ones_q;
   assign running    = running_q;
   assign done       = done_q;

endmodule
